// File: rtl/ip_block_loader_pkg.sv
// rtl/ip_block_loader_pkg.sv - shared constants for the DES front-end block loader
//
// Purpose: DES block width, FSM state encodings, the initial permutation
//   table (IP) and its inverse (IP_INV, used by the back-end final
//   permutation), plus sizing helpers.
// Ports: none (package).

package ip_block_loader_pkg;

  localparam int BLOCK_W = 64;

  // FSM state encodings
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Entry i is the 1-based DES input bit that becomes output bit i+1.
  localparam int IP_TABLE [0:BLOCK_W-1] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int IP_INV_TABLE [0:BLOCK_W-1] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  // Number of IN_W-bit beats per 64-bit block.
  function automatic int beats(input int in_w);
    return BLOCK_W / in_w;
  endfunction

  // Beat counter width: clog2(n), never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ip_block_loader_if.sv
// rtl/ip_block_loader_if.sv - beat input stream and permuted-block output handshake
//
// Purpose: bundles the loader's input beat stream and output block handshake.
// Signals:
//   in_data/in_sob/in_valid  -> loader   input beat, start-of-block, valid
//   in_ready                 <- loader   loader can accept a beat
//   ip_block/out_valid       <- loader   IP(block) and its valid
//   out_ready                -> loader   round logic accepts ip_block
//   sob_err                  <- loader   one-cycle pulse on partial-block discard
// Modports: master = beat source / round logic side, slave = loader.

interface ip_block_loader_if #(
  parameter int IN_W = 8
);
  import ip_block_loader_pkg::*;

  logic [IN_W-1:0]    in_data;
  logic               in_sob;
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] ip_block;
  logic               out_valid;
  logic               out_ready;
  logic               sob_err;

  modport master (
    output in_data, in_sob, in_valid, out_ready,
    input  in_ready, ip_block, out_valid, sob_err
  );

  modport slave (
    input  in_data, in_sob, in_valid, out_ready,
    output in_ready, ip_block, out_valid, sob_err
  );

endinterface

// File: rtl/ip_block_loader_init_permutation.sv
// rtl/ip_block_loader_init_permutation.sv - combinational DES initial permutation
//
// Purpose: pure wiring, perm_o[i] = block_i[IP[i]-1], where index 0 is DES bit 1.
// Ports:
//   block_i  in   64  assembled block, bit 0 = DES bit 1
//   perm_o   out  64  IP(block), bit i = IP-output bit i+1

module ip_block_loader_init_permutation
  import ip_block_loader_pkg::*;
(
  input  logic [BLOCK_W-1:0] block_i,
  output logic [BLOCK_W-1:0] perm_o
);

  for (genvar i = 0; i < BLOCK_W; i++) begin : g_ip
    assign perm_o[i] = block_i[IP_TABLE[i] - 1];
  end

endmodule

// File: rtl/ip_block_loader.sv
// rtl/ip_block_loader.sv - assembles a 64-bit DES block from beats and presents IP(block)
//
// Purpose: collects BEATS = 64/IN_W beats into an assembly register, then
//   holds IP(assembly) with out_valid until the round logic takes it.
//   IN_W must be one of 8, 16, 32, 64.
// Ports:
//   clk  in  1   rising-edge clock
//   rst  in  1   synchronous reset, active-high
//   bus  slave modport of ip_block_loader_if (beat stream in, block handshake out)

module ip_block_loader
  import ip_block_loader_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  ip_block_loader_if.slave    bus
);

  localparam int BEATS = beats(IN_W);
  localparam int CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] asm_q, asm_d;
  logic               sob_err_q, sob_err_d;

  logic [IN_W-1:0]    beat_rev;
  logic               accept;
  logic               restart;
  logic [BLOCK_W-1:0] ip_w;

  // The MSB of each beat is the lowest-numbered DES bit, so reverse the beat
  // before dropping it into the assembly register.
  always_comb begin
    beat_rev = '0;
    for (int j = 0; j < IN_W; j++) begin
      beat_rev[j] = bus.in_data[IN_W-1-j];
    end
  end

  assign accept  = bus.in_valid && bus.in_ready;
  // sob on a non-first beat abandons the partial block
  assign restart = bus.in_sob && (cnt_q != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    sob_err_d = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (restart) begin
            asm_d            = '0;
            asm_d[0 +: IN_W] = beat_rev;
            cnt_d            = CNT_W'(1);
            sob_err_d        = 1'b1;
          end else begin
            asm_d[cnt_q*IN_W +: IN_W] = beat_rev;
            if (cnt_q == LAST_CNT) begin
              state_d = ST_HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        // in_ready is low here, so no beat can slip in on the exit cycle
        if (bus.out_ready) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FILL;
      cnt_q     <= '0;
      asm_q     <= '0;
      sob_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      sob_err_q <= sob_err_d;
    end
  end

  // Permutation of a register that is frozen in HOLD, so ip_block is stable
  // for as long as out_valid is high.
  ip_block_loader_init_permutation u_ip (
    .block_i (asm_q),
    .perm_o  (ip_w)
  );

  assign bus.ip_block  = ip_w;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.in_ready  = (state_q == ST_FILL) && !rst;
  assign bus.sob_err   = sob_err_q;

endmodule
